// File: rtl/card_sprite_renderer.sv
// card_sprite_renderer
//   Draws one playing-card sprite (CARD_W x CARD_H, 3-bit colour codes held
//   in an external synchronous-read memory) onto the VGA raster. The card
//   position and face state are double-buffered: requests are collected
//   during the frame and take effect only on frame_start, so a frame is
//   never drawn half-old, half-new.
//
//   Pipeline (3 cycles from pix_x/pix_y to pixel_out):
//     stage 0 (comb)  : hit test and memory address
//     stage 1 (reg)   : rAddr/RE to memory, hit/face delayed
//     stage 2         : memory returns ramData, hit/face delayed again
//     stage 3 (reg)   : colour select -> pixel_out/pixel_valid
//
//   Optional macro CARD_MIRROR_EN adds input `mirror`, committed at
//   frame_start; when set, the card image is mirrored left-right.
//
// Ports:
//   clock, reset        single clock, asynchronous active-high reset
//   pix_x, pix_y        current raster position; active = visible area
//   frame_start         one-cycle pulse, first cycle of a frame
//   pos_x, pos_y        requested card top-left corner, captured on pos_load
//   show, hide, flip    face requests (priority hide > show > flip)
//   rAddr, RE, ramData  card memory read port (1-cycle registered read)
//   pixel_out           colour code; pixel_valid = opaque, draw it
//   face_state          committed state: 00 HIDDEN, 01 FACE_DOWN, 10 FACE_UP
module card_sprite_renderer #(
  parameter int          CARD_W     = 16,
  parameter int          CARD_H     = 32,
  parameter int          ADDR_W     = 9,
  parameter int          COORD_W    = 10,
  parameter logic [2:0]  BACK_COLOR = 3'b001
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               active,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               pos_load,
  input  logic               show,
  input  logic               hide,
  input  logic               flip,
`ifdef CARD_MIRROR_EN
  input  logic               mirror,
`endif
  output logic [ADDR_W-1:0]  rAddr,
  output logic               RE,
  input  logic [2:0]         ramData,
  output logic [2:0]         pixel_out,
  output logic               pixel_valid,
  output logic [1:0]         face_state
);

  localparam int XW = $clog2(CARD_W);
  localparam int YW = $clog2(CARD_H);

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'b00,
    ST_DOWN   = 2'b01,
    ST_UP     = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_SHOW = 2'b01,
    REQ_HIDE = 2'b10,
    REQ_FLIP = 2'b11
  } req_t;

  state_t             state_q, state_d;
  req_t               req_q, req_d, req_in, req_eff;
  logic [COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic               re_q, re_d;
  logic               hit1_q, hit1_d, up1_q, up1_d;
  logic               hit2_q, up2_q;
  logic [2:0]         pix_q, pix_d;
  logic               valid_q, valid_d;

`ifdef CARD_MIRROR_EN
  logic mirror_q, mirror_d;
  assign mirror_d = frame_start ? mirror : mirror_q;
`endif

  // Request capture. A request seen in the frame_start cycle wins over the
  // pending one, so it is the one committed.
  always_comb begin
    req_in = REQ_NONE;
    if (hide)      req_in = REQ_HIDE;
    else if (show) req_in = REQ_SHOW;
    else if (flip) req_in = REQ_FLIP;
    req_eff  = (req_in != REQ_NONE) ? req_in : req_q;
    req_d    = frame_start ? REQ_NONE : req_eff;
    pend_x_d = pos_load ? pos_x : pend_x_q;
    pend_y_d = pos_load ? pos_y : pend_y_q;
    cx_d     = frame_start ? pend_x_d : cx_q;
    cy_d     = frame_start ? pend_y_d : cy_q;
  end

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_HIDDEN;
    else       state_q <= state_d;
  end

  // FSM: next state, evaluated only at frame_start
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      case (state_q)
        ST_HIDDEN: if (req_eff == REQ_SHOW) state_d = ST_DOWN;
        ST_DOWN: begin
          if (req_eff == REQ_FLIP)      state_d = ST_UP;
          else if (req_eff == REQ_HIDE) state_d = ST_HIDDEN;
        end
        ST_UP: begin
          if (req_eff == REQ_FLIP)      state_d = ST_DOWN;
          else if (req_eff == REQ_HIDE) state_d = ST_HIDDEN;
        end
        default: state_d = ST_HIDDEN;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    face_state = state_q;
  end

  // Stage 0: hit test. The extra MSB makes a negative offset visible, so
  // pixels left of / above the card never alias onto it.
  logic [COORD_W:0] dx, dy;
  logic [XW-1:0]    col;
  logic [ADDR_W-1:0] addr;
  logic             hit;

  always_comb begin
    dx  = {1'b0, pix_x} - {1'b0, cx_q};
    dy  = {1'b0, pix_y} - {1'b0, cy_q};
`ifdef CARD_MIRROR_EN
    // CARD_W is a power of 2, so CARD_W-1-dx is the bitwise inverse.
    col = mirror_q ? ~dx[XW-1:0] : dx[XW-1:0];
`else
    col = dx[XW-1:0];
`endif
    addr = {dy[YW-1:0], col};
    hit  = active && (state_q != ST_HIDDEN) &&
           (dx[COORD_W:XW] == '0) && (dy[COORD_W:YW] == '0);
    // rAddr holds its last value on misses to avoid needless toggling.
    raddr_d = hit ? addr : raddr_q;
    re_d    = hit && (state_q == ST_UP);
    hit1_d  = hit;
    up1_d   = (state_q == ST_UP);
  end

  // Stage 3: colour select once the memory word is available.
  always_comb begin
    pix_d   = 3'b000;
    valid_d = 1'b0;
    if (hit2_q && up2_q) begin
      pix_d   = ramData;
      valid_d = (ramData != 3'b000);
    end else if (hit2_q) begin
      pix_d   = BACK_COLOR;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q    <= REQ_NONE;
      pend_x_q <= '0;
      pend_y_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      raddr_q  <= '0;
      re_q     <= 1'b0;
      hit1_q   <= 1'b0;
      up1_q    <= 1'b0;
      hit2_q   <= 1'b0;
      up2_q    <= 1'b0;
      pix_q    <= 3'b000;
      valid_q  <= 1'b0;
`ifdef CARD_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      req_q    <= req_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      raddr_q  <= raddr_d;
      re_q     <= re_d;
      hit1_q   <= hit1_d;
      up1_q    <= up1_d;
      hit2_q   <= hit1_q;
      up2_q    <= up1_q;
      pix_q    <= pix_d;
      valid_q  <= valid_d;
`ifdef CARD_MIRROR_EN
      mirror_q <= mirror_d;
`endif
    end
  end

  assign rAddr       = raddr_q;
  assign RE          = re_q;
  assign pixel_out   = pix_q;
  assign pixel_valid = valid_q;

endmodule

// File: tb/tb_card_sprite_renderer.sv
module tb_card_sprite_renderer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pix_x = '0, pix_y = '0, pos_x = '0, pos_y = '0;
  logic       active = 1'b0, frame_start = 1'b0, pos_load = 1'b0;
  logic       show = 1'b0, hide = 1'b0, flip = 1'b0;
  logic [8:0] rAddr;
  logic       RE;
  logic [2:0] ram_data = 3'b000;
  logic [2:0] pixel_out;
  logic       pixel_valid;
  logic [1:0] face_state;

  logic [2:0] mem [512];

  int n_cmp = 0;
  int n_err = 0;

  // expected {pixel_valid, pixel_out} at +3 and {RE, addr_check, rAddr} at +1
  logic [3:0]  exp_pix_q[$];
  logic [10:0] exp_re_q[$];

  logic drv_flag = 1'b0;
  logic d1, d2, d3;

  card_sprite_renderer dut (
    .clock       (clock),
    .reset       (reset),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .active      (active),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_load    (pos_load),
    .show        (show),
    .hide        (hide),
    .flip        (flip),
`ifdef CARD_MIRROR_EN
    .mirror      (1'b0),
`endif
    .rAddr       (rAddr),
    .RE          (RE),
    .ramData     (ram_data),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .face_state  (face_state)
  );

  // clock / reset-independent infrastructure
  always #5 clock = ~clock;

  // card memory: synchronous read, one cycle latency
  always @(posedge clock) if (RE) ram_data <= mem[rAddr];

  // marks which cycles carry a checked pixel, delayed to the output stages
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
    end else begin
      d1 <= drv_flag; d2 <= d1; d3 <= d2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // monitor / scoreboard
  initial begin
    logic [3:0]  ep;
    logic [10:0] er;
    forever begin
      @(negedge clock);
      if (!reset && d1) begin
        n_cmp++;
        if (exp_re_q.size() == 0) begin
          n_err++;
          $display("FAIL re_queue: got RE=%0b with no expectation", RE);
        end else begin
          er = exp_re_q.pop_front();
          if (RE !== er[10] || (er[9] && rAddr !== er[8:0])) begin
            n_err++;
            $display("FAIL re_addr: got RE=%0b rAddr=%03h, want RE=%0b rAddr=%03h (chk=%0b)",
                     RE, rAddr, er[10], er[8:0], er[9]);
          end
        end
      end
      if (!reset && d3) begin
        n_cmp++;
        if (exp_pix_q.size() == 0) begin
          n_err++;
          $display("FAIL pix_queue: got pixel with no expectation");
        end else begin
          ep = exp_pix_q.pop_front();
          if ({pixel_valid, pixel_out} !== ep) begin
            n_err++;
            $display("FAIL pixel: got valid=%0b pix=%03b, want valid=%0b pix=%03b",
                     pixel_valid, pixel_out, ep[3], ep[2:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // one clock: inputs change #1 after the edge; pulses last one cycle
  task automatic tick();
    @(posedge clock);
    #1;
    frame_start = 1'b0; pos_load = 1'b0;
    show = 1'b0; hide = 1'b0; flip = 1'b0;
  endtask

  // drive one raster pixel and queue its expected response
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic act,
                     input logic [3:0] ep, input logic er, input logic ea,
                     input logic [8:0] eaddr);
    pix_x = x; pix_y = y; active = act;
    drv_flag = 1'b1;
    exp_pix_q.push_back(ep);
    exp_re_q.push_back({er, ea, eaddr});
    tick();
    drv_flag = 1'b0;
    active = 1'b0;
  endtask

  task automatic load_pos(input logic [9:0] x, input logic [9:0] y);
    pos_x = x; pos_y = y; pos_load = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 3'b000;
    mem[9'h011] = 3'b101;
    mem[9'h095] = 3'b011;
    mem[9'h000] = 3'b111;
    mem[9'h1FF] = 3'b110;

    // reset state
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_face", 9'(face_state), 9'h0);
    chk("rst_valid", 9'(pixel_valid), 9'h0);
    chk("rst_re", 9'(RE), 9'h0);
    chk("rst_raddr", rAddr, 9'h0);
    chk("rst_pix", 9'(pixel_out), 9'h0);

    // hidden card: nothing drawn
    pix(10'd0, 10'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);

    // show, then frame_start with same-cycle position load
    show = 1'b1; tick();
    load_pos(10'd100, 10'd50); frame_start = 1'b1; tick();
    chk("face_down", 9'(face_state), 9'h1);
    pix(10'd100, 10'd50, 1'b1, 4'b1001, 1'b0, 1'b1, 9'h000);
    pix(10'd100, 10'd50, 1'b0, 4'b0000, 1'b0, 1'b0, 9'h0);

    // flip to face up
    flip = 1'b1; frame_start = 1'b1; tick();
    chk("face_up", 9'(face_state), 9'h2);
    pix(10'd101, 10'd51, 1'b1, 4'b1101, 1'b1, 1'b1, 9'h011);
    pix(10'd102, 10'd52, 1'b1, 4'b0000, 1'b1, 1'b1, 9'h022); // transparent
    pix(10'd116, 10'd50, 1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);   // dx = 16
    pix(10'd115, 10'd81, 1'b1, 4'b1110, 1'b1, 1'b1, 9'h1FF); // last pixel
    pix(10'd99,  10'd50, 1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);   // dx = -1
    pix(10'd100, 10'd49, 1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);   // dy = -1
    pix(10'd100, 10'd82, 1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);   // dy = 32

    // card near bottom-right corner
    load_pos(10'd250, 10'd230); frame_start = 1'b1; tick();
    pix(10'd255, 10'd239, 1'b1, 4'b1011, 1'b1, 1'b1, 9'h095);
    pix(10'd250, 10'd230, 1'b1, 4'b1111, 1'b1, 1'b1, 9'h000);
    pix(10'd249, 10'd230, 1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);
    pix(10'd250, 10'd229, 1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);

    // mid-frame position load does not move the drawn card
    load_pos(10'd10, 10'd10);
    pix(10'd250, 10'd230, 1'b1, 4'b1111, 1'b1, 1'b1, 9'h000);
    pix(10'd10,  10'd10,  1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);
    // hide + flip together: hide wins, still drawn until frame_start
    hide = 1'b1; flip = 1'b1;
    pix(10'd255, 10'd239, 1'b1, 4'b1011, 1'b1, 1'b1, 9'h095);
    // pixel in the commit cycle keeps the face-up state it sampled
    frame_start = 1'b1;
    pix(10'd250, 10'd230, 1'b1, 4'b1111, 1'b1, 1'b1, 9'h000);
    chk("hidden", 9'(face_state), 9'h0);
    pix(10'd10, 10'd10, 1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);

    // later request overwrites: show then flip -> flip ignored while hidden
    show = 1'b1; tick();
    flip = 1'b1; tick();
    frame_start = 1'b1; tick();
    chk("overwrite", 9'(face_state), 9'h0);

    show = 1'b1; frame_start = 1'b1; tick();
    chk("show2", 9'(face_state), 9'h1);
    pix(10'd10, 10'd10, 1'b1, 4'b1001, 1'b0, 1'b1, 9'h000);
    pix(10'd25, 10'd41, 1'b1, 4'b1001, 1'b0, 1'b1, 9'h1FF);
    show = 1'b1; frame_start = 1'b1; tick();
    chk("show_nochg", 9'(face_state), 9'h1);

    // face-up card, then reset mid-frame with pixels in flight
    flip = 1'b1; frame_start = 1'b1; tick();
    chk("face_up2", 9'(face_state), 9'h2);
    pix(10'd10, 10'd10, 1'b1, 4'b1111, 1'b1, 1'b1, 9'h000);
    pix(10'd10, 10'd10, 1'b1, 4'b1111, 1'b1, 1'b1, 9'h000);
    pix(10'd10, 10'd10, 1'b1, 4'b1111, 1'b1, 1'b1, 9'h000);
    chk("pre_rst_valid", 9'(pixel_valid), 9'h1);
    #1;
    reset = 1'b1;
    exp_pix_q.delete();
    exp_re_q.delete();
    #1;
    chk("mid_rst_face", 9'(face_state), 9'h0);
    chk("mid_rst_valid", 9'(pixel_valid), 9'h0);
    chk("mid_rst_pix", 9'(pixel_out), 9'h0);
    chk("mid_rst_re", 9'(RE), 9'h0);
    chk("mid_rst_raddr", rAddr, 9'h0);
    tick();
    reset = 1'b0;
    pix(10'd0, 10'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 9'h0);
    repeat (4) tick();

    chk("queues_drained", 9'(exp_pix_q.size() + exp_re_q.size()), 9'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
